// File: rtl/shift_right_seq.sv
// Multi-cycle right shifter: logical or arithmetic shift of a WIDTH-bit operand
// by a SHAMT_W-bit amount, one log-shifter stage (1, 2, 4, ...) per clock.
// Fixed latency of SHAMT_W cycles from the accepted start to the done pulse.
//
// Handshake: start is sampled only while busy=0 (IDLE or DONE). The edge
// that samples start=1 captures data_in, shamt and the fill bit. done is a
// one-cycle pulse, and result is valid while done=1. result then holds until
// the next operation completes.
module shift_right_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               arith,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    localparam int STAGE_W = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;
    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(SHAMT_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [STAGE_W-1:0]   stage_q, stage_d;
    logic [WIDTH-1:0]     work_q, work_d;
    logic [SHAMT_W-1:0]   shamt_q, shamt_d;
    logic                 fill_q, fill_d;
    logic [WIDTH-1:0]     result_q, result_d;

    logic [SHAMT_W-1:0]   step_amt;
    logic [WIDTH-1:0]     fill_mask;
    logic [WIDTH-1:0]     stage_out;

    // One log-shifter stage: shift the work register by 2**stage, filling the vacated top bits.
    always_comb begin
        step_amt  = SHAMT_W'(1) << stage_q;
        fill_mask = ~({WIDTH{1'b1}} >> step_amt);
        stage_out = (work_q >> step_amt) | (fill_q ? fill_mask : '0);
    end

    // State register and datapath registers; async reset abandons any in-flight operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            stage_q  <= '0;
            work_q   <= '0;
            shamt_q  <= '0;
            fill_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            stage_q  <= stage_d;
            work_q   <= work_d;
            shamt_q  <= shamt_d;
            fill_q   <= fill_d;
            result_q <= result_d;
        end
    end

    // Next-state and datapath control: load on an accepted start, one stage per cycle in SHIFT.
    always_comb begin
        state_d  = state_q;
        stage_d  = stage_q;
        work_d   = work_q;
        shamt_d  = shamt_q;
        fill_d   = fill_q;
        result_d = result_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    work_d  = data_in;
                    shamt_d = shamt;
                    fill_d  = arith & data_in[WIDTH-1];
                    stage_d = '0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (shamt_q[stage_q]) begin
                    work_d = stage_out;
                end
                if (stage_q == LAST_STAGE) begin
                    // result only changes here, so it never shows intermediate work.
                    result_d = work_d;
                    state_d  = DONE;
                end else begin
                    stage_d = stage_q + STAGE_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the state register.
    always_comb begin
        busy   = (state_q == SHIFT);
        done   = (state_q == DONE);
        result = result_q;
    end

endmodule
